// File: rtl/csr_access_unit_pkg.sv
// Shared types, funct3 encodings and decode helpers for the Zicsr execute-stage sequencer.
package csr_access_unit_pkg;

    typedef enum logic [1:0] {
        CSR_NOP   = 2'b00,
        CSR_READ  = 2'b01,
        CSR_WRITE = 2'b10
    } csr_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    function automatic logic csr_ro_addr(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    function automatic logic csr_is_imm(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic csr_legal_funct3(input logic [2:0] funct3);
        return (funct3 == F3_CSRRW)  || (funct3 == F3_CSRRS)  || (funct3 == F3_CSRRC) ||
               (funct3 == F3_CSRRWI) || (funct3 == F3_CSRRSI) || (funct3 == F3_CSRRCI);
    endfunction

    function automatic logic csr_is_swap(input logic [2:0] funct3);
        return (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
    endfunction

    // Set/clear forms with rs1/zimm index 0 read the CSR but must not write it.
    function automatic logic csr_write_suppress(input logic [2:0] funct3, input logic [4:0] rs1_idx);
        return ((funct3 == F3_CSRRS)  || (funct3 == F3_CSRRC) ||
                (funct3 == F3_CSRRSI) || (funct3 == F3_CSRRCI)) && (rs1_idx == 5'd0);
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Decode, CSR-file and writeback signals of the CSR access unit, grouped for the port list.
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [11:0]     in_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [4:0]      in_rs1_idx;
    logic [4:0]      in_rd;
    logic            flush;

    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_data;
    logic            wb_illegal;

    modport slave (
        input  in_valid, in_funct3, in_addr, in_rs1_data, in_rs1_idx, in_rd, flush,
        input  csr_rdata, wb_ready,
        output in_ready, csr_op, csr_addr, csr_wdata,
        output wb_valid, wb_rd, wb_we, wb_data, wb_illegal
    );

    modport master (
        output in_valid, in_funct3, in_addr, in_rs1_data, in_rs1_idx, in_rd, flush,
        output csr_rdata, wb_ready,
        input  in_ready, csr_op, csr_addr, csr_wdata,
        input  wb_valid, wb_rd, wb_we, wb_data, wb_illegal
    );
endinterface

// File: rtl/csr_access_unit_wdata_gen.sv
// Combinational new-value computation for CSRRW/RS/RC and their immediate forms.
module csr_wdata_gen
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_src,
    input  logic [4:0]      i_rs1_idx,
    output logic [XLEN-1:0] o_new_val,
    output logic            o_write_suppress
);

    // funct3[1:0] selects swap/set/clear identically for register and immediate forms.
    always_comb begin
        o_new_val = '0;
        case (i_funct3[1:0])
            2'b01:   o_new_val = i_src;
            2'b10:   o_new_val = i_old | i_src;
            2'b11:   o_new_val = i_old & ~i_src;
            default: o_new_val = '0;
        endcase
    end

    assign o_write_suppress = csr_write_suppress(i_funct3, i_rs1_idx);

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr execute-stage sequencer: one instruction in flight, READ then WRITE to the CSR file,
// old value returned to writeback.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit RO_CHECK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    csr_access_unit_if.slave   bus
);

    state_e          r_state;
    logic            r_inReady;
    csr_op_e         r_csrOp;
    logic [11:0]     r_csrAddr;
    logic [XLEN-1:0] r_csrWdata;
    logic            r_wbValid;
    logic [4:0]      r_wbRd;
    logic            r_wbWe;
    logic [XLEN-1:0] r_wbData;
    logic            r_wbIllegal;

    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1Data;
    logic [4:0]      r_rs1Idx;
    logic [4:0]      r_rd;
    logic            r_illegal;
    logic [XLEN-1:0] r_old;

    logic            w_inSuppress;
    logic            w_inIllegal;
    logic            w_inSkipRead;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_newVal;
    logic            w_writeSuppress;

    // Illegality is decided at accept time so that an illegal instruction never issues a READ.
    assign w_inSuppress = csr_write_suppress(bus.in_funct3, bus.in_rs1_idx);
    assign w_inIllegal  = !csr_legal_funct3(bus.in_funct3) ||
                          (RO_CHECK_EN && csr_ro_addr(bus.in_addr) && !w_inSuppress);
    assign w_inSkipRead = w_inIllegal || (csr_is_swap(bus.in_funct3) && (bus.in_rd == 5'd0));

    assign w_old = (r_csrOp == CSR_READ) ? bus.csr_rdata : '0;
    assign w_src = csr_is_imm(r_funct3) ? XLEN'(r_rs1Idx) : r_rs1Data;

    csr_wdata_gen #(
        .XLEN(XLEN)
    ) u_wdataGen (
        .i_funct3        (r_funct3),
        .i_old           (w_old),
        .i_src           (w_src),
        .i_rs1_idx       (r_rs1Idx),
        .o_new_val       (w_newVal),
        .o_write_suppress(w_writeSuppress)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_inReady   <= 1'b1;
            r_csrOp     <= CSR_NOP;
            r_csrAddr   <= '0;
            r_csrWdata  <= '0;
            r_wbValid   <= 1'b0;
            r_wbRd      <= '0;
            r_wbWe      <= 1'b0;
            r_wbData    <= '0;
            r_wbIllegal <= 1'b0;
            r_funct3    <= '0;
            r_rs1Data   <= '0;
            r_rs1Idx    <= '0;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
            r_old       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && !bus.flush) begin
                        r_state   <= S_READ;
                        r_inReady <= 1'b0;
                        r_funct3  <= bus.in_funct3;
                        r_rs1Data <= bus.in_rs1_data;
                        r_rs1Idx  <= bus.in_rs1_idx;
                        r_rd      <= bus.in_rd;
                        r_illegal <= w_inIllegal;
                        r_csrAddr <= bus.in_addr;
                        r_csrOp   <= w_inSkipRead ? CSR_NOP : CSR_READ;
                    end
                end
                // csr_rdata is combinational, so the old value is captured in the READ cycle itself.
                S_READ: begin
                    if (bus.flush) begin
                        r_state   <= S_IDLE;
                        r_inReady <= 1'b1;
                        r_csrOp   <= CSR_NOP;
                    end else begin
                        r_state    <= S_WRITE;
                        r_old      <= w_old;
                        r_csrWdata <= w_newVal;
                        r_csrOp    <= (r_illegal || w_writeSuppress) ? CSR_NOP : CSR_WRITE;
                    end
                end
                S_WRITE: begin
                    r_state     <= S_RESP;
                    r_csrOp     <= CSR_NOP;
                    r_wbValid   <= 1'b1;
                    r_wbRd      <= r_rd;
                    r_wbWe      <= !r_illegal && (r_rd != 5'd0);
                    r_wbData    <= r_old;
                    r_wbIllegal <= r_illegal;
                end
                S_RESP: begin
                    if (bus.wb_ready) begin
                        r_state   <= S_IDLE;
                        r_wbValid <= 1'b0;
                        r_inReady <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_inReady;
    assign bus.csr_op     = r_csrOp;
    assign bus.csr_addr   = r_csrAddr;
    assign bus.csr_wdata  = r_csrWdata;
    assign bus.wb_valid   = r_wbValid;
    assign bus.wb_rd      = r_wbRd;
    assign bus.wb_we      = r_wbWe;
    assign bus.wb_data    = r_wbData;
    assign bus.wb_illegal = r_wbIllegal;

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: a reference model predicts CSR ops and writeback,
// a negedge monitor compares everything the DUT presents.
module tb_csr_access_unit;

    localparam int XLEN = 32;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        int          cyc;
    } exp_t;

    localparam logic [11:0] ADDRS [8] = '{12'h340, 12'h341, 12'h300, 12'h305,
                                          12'hC00, 12'hC01, 12'h8C0, 12'hF14};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    csr_access_unit_if #(.XLEN(XLEN)) bus();

    csr_access_unit #(
        .XLEN       (XLEN),
        .RO_CHECK_EN(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] csrMem [0:4095] = '{default: 32'h0};
    logic [31:0] refMem [0:4095] = '{default: 32'h0};
    logic        preEn = 1'b0;
    logic [11:0] preAddr = '0;
    logic [31:0] preData = '0;

    exp_t expQ [$];
    int   cyc = 0;
    int   passCount = 0;
    int   checkCount = 0;
    bit   monEnable = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // CSR file stand-in: combinational read, write on the edge that ends a WRITE cycle.
    assign bus.csr_rdata = csrMem[bus.csr_addr];
    always @(posedge clk) begin
        if (preEn) csrMem[preAddr] <= preData;
        else if (bus.csr_op == 2'b10) csrMem[bus.csr_addr] <= bus.csr_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (monEnable) begin
            if (bus.csr_op !== 2'b00) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedCsrOp", {62'b0, bus.csr_op}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("csrOp", {62'b0, bus.csr_op}, e.kind);
                    checkOutput("csrAddr", {52'b0, bus.csr_addr}, {52'b0, e.addr});
                    if (e.kind == 2) checkOutput("csrWdata", {32'b0, bus.csr_wdata}, {32'b0, e.data});
                    checkOutput("csrOpCycle", cyc, e.cyc);
                end
            end
            if (bus.wb_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWb", 64'd1, 64'd0);
                end else begin
                    e = expQ[0];
                    checkOutput("wbOrder", 64'd3, e.kind);
                    checkOutput("wbRd", {59'b0, bus.wb_rd}, {59'b0, e.rd});
                    checkOutput("wbWe", {63'b0, bus.wb_we}, {63'b0, e.we});
                    checkOutput("wbData", {32'b0, bus.wb_data}, {32'b0, e.data});
                    checkOutput("wbIllegal", {63'b0, bus.wb_illegal}, {63'b0, e.ill});
                    checkOutput("inReadyBusy", {63'b0, bus.in_ready}, 64'd0);
                    if (bus.wb_ready) begin
                        checkOutput("wbCycle", cyc, e.cyc);
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    // Reference model: derives the expected op/writeback sequence from the Zicsr rules.
    task automatic predictAndPush(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] data,
                                  input logic [4:0] idx, input logic [4:0] rd, input int a,
                                  input int stall, input int mode);
        exp_t        e;
        logic [1:0]  k;
        logic [31:0] src, old, nv;
        bit          legal, suppressed, ill, reads, writes;
        legal      = (f3 != 3'd0) && (f3 != 3'd4);
        k          = f3[1:0];
        src        = f3[2] ? {27'b0, idx} : data;
        suppressed = (k == 2'd2 || k == 2'd3) && (idx == 5'd0);
        ill        = !legal || ((addr[11:10] == 2'b11) && !suppressed);
        reads      = !ill && !(k == 2'd1 && rd == 5'd0);
        writes     = !ill && !suppressed;
        old        = reads ? refMem[addr] : 32'd0;
        case (k)
            2'd1:    nv = src;
            2'd2:    nv = old | src;
            2'd3:    nv = old & ~src;
            default: nv = 32'd0;
        endcase
        e = '{kind: 1, addr: addr, data: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b0, cyc: a};
        if (reads) expQ.push_back(e);
        if (mode == 1) return;
        if (writes) begin
            e = '{kind: 2, addr: addr, data: nv, rd: 5'd0, we: 1'b0, ill: 1'b0, cyc: a + 1};
            expQ.push_back(e);
            refMem[addr] = nv;
        end
        if (mode == 3) return;
        e = '{kind: 3, addr: addr, data: old, rd: rd, we: (!ill && rd != 5'd0), ill: ill, cyc: a + 2 + stall};
        expQ.push_back(e);
    endtask

    task automatic setCsr(input logic [11:0] addr, input logic [31:0] val);
        preAddr = addr;
        preData = val;
        preEn   = 1'b1;
        @(posedge clk); #1;
        preEn   = 1'b0;
        refMem[addr] = val;
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkCount++;
            $display("[TB] FAIL idleWait: in_ready=%b after 100 cycles, expected 1", bus.in_ready);
        end
    endtask

    // mode: 0 normal, 1 flush in S_READ, 2 flush in S_WRITE, 3 reset in S_WRITE
    task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] data,
                                 input logic [4:0] idx, input logic [4:0] rd, input int stallIn,
                                 input int mode);
        int a, stall;
        bit ok;
        stall = (mode == 1 || mode == 3) ? 0 : stallIn;
        waitIdle(ok);
        if (!ok) return;
        a = cyc + 1;
        predictAndPush(f3, addr, data, idx, rd, a, stall, mode);
        bus.in_valid    = 1'b1;
        bus.in_funct3   = f3;
        bus.in_addr     = addr;
        bus.in_rs1_data = data;
        bus.in_rs1_idx  = idx;
        bus.in_rd       = rd;
        if (stall > 0) bus.wb_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.in_funct3   = 3'($urandom);
        bus.in_addr     = 12'($urandom);
        bus.in_rs1_data = $urandom;
        bus.in_rs1_idx  = 5'($urandom);
        bus.in_rd       = 5'($urandom);
        case (mode)
            1: begin
                bus.flush = 1'b1;
                @(posedge clk); #1;
                bus.flush = 1'b0;
                checkOutput("flushReadIdle", {63'b0, bus.in_ready}, 64'd1);
            end
            2: begin
                @(posedge clk); #1;
                bus.flush = 1'b1;
                @(posedge clk); #1;
                bus.flush = 1'b0;
            end
            3: begin
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                checkOutput("resetCsrOp", {62'b0, bus.csr_op}, 64'd0);
                checkOutput("resetInReady", {63'b0, bus.in_ready}, 64'd1);
                checkOutput("resetWbValid", {63'b0, bus.wb_valid}, 64'd0);
                reset = 1'b0;
            end
            default: ;
        endcase
        if (mode == 0 || mode == 2) begin
            while (cyc < a + 2 + stall) begin
                @(posedge clk); #1;
            end
            bus.wb_ready = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        bus.in_valid    = 1'b0;
        bus.in_funct3   = '0;
        bus.in_addr     = '0;
        bus.in_rs1_data = '0;
        bus.in_rs1_idx  = '0;
        bus.in_rd       = '0;
        bus.flush       = 1'b0;
        bus.wb_ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstInReady", {63'b0, bus.in_ready}, 64'd1);
        checkOutput("rstCsrOp", {62'b0, bus.csr_op}, 64'd0);
        checkOutput("rstCsrAddr", {52'b0, bus.csr_addr}, 64'd0);
        checkOutput("rstCsrWdata", {32'b0, bus.csr_wdata}, 64'd0);
        checkOutput("rstWbValid", {63'b0, bus.wb_valid}, 64'd0);
        checkOutput("rstWbData", {32'b0, bus.wb_data}, 64'd0);
        checkOutput("rstWbWe", {63'b0, bus.wb_we}, 64'd0);
        checkOutput("rstWbIllegal", {63'b0, bus.wb_illegal}, 64'd0);
        reset = 1'b0;
        monEnable = 1'b1;

        setCsr(12'h340, 32'h0000_1234);
        applyStimulus(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd7, 5'd5, 0, 0);
        setCsr(12'h300, 32'h0000_00F0);
        applyStimulus(3'b010, 12'h300, 32'h0000_000F, 5'd3, 5'd4, 0, 0);
        applyStimulus(3'b111, 12'h300, 32'h0000_0000, 5'd1, 5'd6, 0, 0);
        setCsr(12'hC00, 32'h0000_CAFE);
        applyStimulus(3'b010, 12'hC00, 32'h1111_1111, 5'd0, 5'd8, 0, 0);
        applyStimulus(3'b001, 12'hC00, 32'h2222_2222, 5'd2, 5'd9, 0, 0);
        applyStimulus(3'b001, 12'h341, 32'h0000_0055, 5'd1, 5'd0, 0, 0);
        applyStimulus(3'b100, 12'h340, 32'h0000_0077, 5'd1, 5'd3, 0, 0);
        applyStimulus(3'b001, 12'h340, 32'h0000_AAAA, 5'd1, 5'd2, 0, 1);
        applyStimulus(3'b010, 12'h340, 32'h0000_0F00, 5'd4, 5'd3, 0, 2);

        // A flush in the accept cycle must block the instruction entirely.
        waitIdle(ok);
        bus.in_valid    = 1'b1;
        bus.flush       = 1'b1;
        bus.in_funct3   = 3'b001;
        bus.in_addr     = 12'h340;
        bus.in_rs1_data = 32'h5A5A_5A5A;
        bus.in_rs1_idx  = 5'd1;
        bus.in_rd       = 5'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        checkOutput("flushIdleReady", {63'b0, bus.in_ready}, 64'd1);
        repeat (3) @(posedge clk);

        applyStimulus(3'b011, 12'h340, 32'h0000_00FF, 5'd5, 5'd10, 5, 0);
        applyStimulus(3'b001, 12'h305, 32'h0000_0077, 5'd1, 5'd11, 0, 3);

        for (int n = 0; n < 200; n++) begin
            int r, mode;
            logic [4:0] idx, rd;
            idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r    = $urandom_range(0, 19);
            mode = (r == 0) ? 3 : (r < 3) ? 1 : (r < 5) ? 2 : 0;
            applyStimulus(3'($urandom_range(0, 7)), ADDRS[$urandom_range(0, 7)], $urandom,
                          idx, rd, $urandom_range(0, 3), mode);
        end

        waitIdle(ok);
        repeat (4) @(posedge clk);
        checkOutput("queueDrained", expQ.size(), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
